// File: rtl/idu_pkg.sv
// Shared opcode, register and class definitions for the dual-issue dispatch unit.
package idu_pkg;

  localparam int TYPE_W = 8;
  localparam int REG_W  = 8;

  localparam logic [TYPE_W-1:0] NOP = 8'h00;
  localparam logic [TYPE_W-1:0] ADD = 8'h01;
  localparam logic [TYPE_W-1:0] SUB = 8'h02;
  localparam logic [TYPE_W-1:0] MUL = 8'h03;
  localparam logic [TYPE_W-1:0] DIV = 8'h04;

  localparam logic [REG_W-1:0] R0 = 8'h00;
  localparam logic [REG_W-1:0] R1 = 8'h01;
  localparam logic [REG_W-1:0] R2 = 8'h02;
  localparam logic [REG_W-1:0] R3 = 8'h03;
  localparam logic [REG_W-1:0] R4 = 8'h04;
  localparam logic [REG_W-1:0] R5 = 8'h05;
  localparam logic [REG_W-1:0] R6 = 8'h06;
  localparam logic [REG_W-1:0] R7 = 8'h07;

  typedef enum logic [1:0] {
    CLS_N = 2'd0,
    CLS_A = 2'd1,
    CLS_M = 2'd2
  } idu_class_e;

  // Unknown opcodes fall into CLS_N so they never consume an RS entry.
  function automatic idu_class_e opcode_class(input logic [TYPE_W-1:0] op);
    idu_class_e cls;
    case (op)
      ADD, SUB: cls = CLS_A;
      MUL, DIV: cls = CLS_M;
      default:  cls = CLS_N;
    endcase
    return cls;
  endfunction

  function automatic logic [TYPE_W-1:0] sanitize_opcode(input logic [TYPE_W-1:0] op);
    return (opcode_class(op) == CLS_N) ? NOP : op;
  endfunction

  // Clamp a 2-bit free-entry status to the 0..2 range the dispatcher reasons about.
  function automatic logic [1:0] clamp_status(input logic [1:0] st);
    return (st == 2'd3) ? 2'd2 : st;
  endfunction

endpackage

// File: rtl/idu_dispatch_if.sv
// Front-end / RS-side bundle of the dispatch unit: two decoded instructions in,
// RS free-entry status in, consume mask and two registered dispatched slots out.
interface idu_dispatch_if #(
  parameter int TYPE_W = 8,
  parameter int REG_W  = 8
);

  logic [TYPE_W-1:0] IDU_in_inst1_type;
  logic [REG_W-1:0]  IDU_in_inst1_destination_reg;
  logic [REG_W-1:0]  IDU_in_inst1_source_reg1;
  logic [REG_W-1:0]  IDU_in_inst1_source_reg2;
  logic [TYPE_W-1:0] IDU_in_inst2_type;
  logic [REG_W-1:0]  IDU_in_inst2_destination_reg;
  logic [REG_W-1:0]  IDU_in_inst2_source_reg1;
  logic [REG_W-1:0]  IDU_in_inst2_source_reg2;
  logic [1:0]        AR_Status;
  logic [1:0]        MR_Status;

  logic [1:0]        select_instruction;
  logic [TYPE_W-1:0] IDU_out_inst1_type;
  logic [REG_W-1:0]  IDU_out_inst1_destination_reg;
  logic [REG_W-1:0]  IDU_out_inst1_source_reg1;
  logic [REG_W-1:0]  IDU_out_inst1_source_reg2;
  logic [TYPE_W-1:0] IDU_out_inst2_type;
  logic [REG_W-1:0]  IDU_out_inst2_destination_reg;
  logic [REG_W-1:0]  IDU_out_inst2_source_reg1;
  logic [REG_W-1:0]  IDU_out_inst2_source_reg2;

  modport master (
    output IDU_in_inst1_type, IDU_in_inst1_destination_reg,
           IDU_in_inst1_source_reg1, IDU_in_inst1_source_reg2,
           IDU_in_inst2_type, IDU_in_inst2_destination_reg,
           IDU_in_inst2_source_reg1, IDU_in_inst2_source_reg2,
           AR_Status, MR_Status,
    input  select_instruction,
           IDU_out_inst1_type, IDU_out_inst1_destination_reg,
           IDU_out_inst1_source_reg1, IDU_out_inst1_source_reg2,
           IDU_out_inst2_type, IDU_out_inst2_destination_reg,
           IDU_out_inst2_source_reg1, IDU_out_inst2_source_reg2
  );

  modport slave (
    input  IDU_in_inst1_type, IDU_in_inst1_destination_reg,
           IDU_in_inst1_source_reg1, IDU_in_inst1_source_reg2,
           IDU_in_inst2_type, IDU_in_inst2_destination_reg,
           IDU_in_inst2_source_reg1, IDU_in_inst2_source_reg2,
           AR_Status, MR_Status,
    output select_instruction,
           IDU_out_inst1_type, IDU_out_inst1_destination_reg,
           IDU_out_inst1_source_reg1, IDU_out_inst1_source_reg2,
           IDU_out_inst2_type, IDU_out_inst2_destination_reg,
           IDU_out_inst2_source_reg1, IDU_out_inst2_source_reg2
  );

endinterface

// File: rtl/idu_slot_reg.sv
// One dispatched-instruction output slot: loads the offered fields when the slot
// is dispatched, otherwise fills with an all-zero NOP; synchronous active-low reset.
module idu_slot_reg #(
  parameter int TYPE_W = 8,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [TYPE_W-1:0] type_i,
  input  logic [REG_W-1:0]  dst_i,
  input  logic [REG_W-1:0]  src1_i,
  input  logic [REG_W-1:0]  src2_i,
  output logic [TYPE_W-1:0] type_o,
  output logic [REG_W-1:0]  dst_o,
  output logic [REG_W-1:0]  src1_o,
  output logic [REG_W-1:0]  src2_o
);

  logic [TYPE_W-1:0] type_q, type_d;
  logic [REG_W-1:0]  dst_q,  dst_d;
  logic [REG_W-1:0]  src1_q, src1_d;
  logic [REG_W-1:0]  src2_q, src2_d;

  always_comb begin
    type_d = '0;
    dst_d  = '0;
    src1_d = '0;
    src2_d = '0;
    if (load_i) begin
      type_d = type_i;
      dst_d  = dst_i;
      src1_d = src1_i;
      src2_d = src2_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      type_q <= '0;
      dst_q  <= '0;
      src1_q <= '0;
      src2_q <= '0;
    end else begin
      type_q <= type_d;
      dst_q  <= dst_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
    end
  end

  assign type_o = type_q;
  assign dst_o  = dst_q;
  assign src1_o = src1_q;
  assign src2_o = src2_q;

endmodule

// File: rtl/idu_dispatch.sv
// Dual-issue in-order dispatch: combinational consume mask plus registered slots.
// Optional build macro IDU_INTRA_PAIR_DEP_CHECK_EN holds back inst2 when it reads inst1's result.
module idu_dispatch #(
  parameter int TYPE_W = 8,
  parameter int REG_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  idu_dispatch_if.slave      bus
);
  import idu_pkg::*;

  idu_class_e cls1, cls2;
  logic [1:0] ar_free, mr_free;
  logic [1:0] ar_left, mr_left;
  logic       d1, d2, pair_dep;
  logic [TYPE_W-1:0] type1_clean, type2_clean;

  assign cls1        = opcode_class(bus.IDU_in_inst1_type);
  assign cls2        = opcode_class(bus.IDU_in_inst2_type);
  assign type1_clean = sanitize_opcode(bus.IDU_in_inst1_type);
  assign type2_clean = sanitize_opcode(bus.IDU_in_inst2_type);
  assign ar_free     = clamp_status(bus.AR_Status);
  assign mr_free     = clamp_status(bus.MR_Status);

`ifdef IDU_INTRA_PAIR_DEP_CHECK_EN
  assign pair_dep = (cls1 != CLS_N) &&
                    ((bus.IDU_in_inst1_destination_reg == bus.IDU_in_inst2_source_reg1) ||
                     (bus.IDU_in_inst1_destination_reg == bus.IDU_in_inst2_source_reg2));
`else
  assign pair_dep = 1'b0;
`endif

  always_comb begin
    d1      = 1'b0;
    d2      = 1'b0;
    ar_left = ar_free;
    mr_left = mr_free;
    case (cls1)
      CLS_A:   d1 = (ar_free != 2'd0);
      CLS_M:   d1 = (mr_free != 2'd0);
      default: d1 = 1'b1;
    endcase
    // inst1 takes its entry first so inst2 only sees what remains.
    if (d1 && cls1 == CLS_A) ar_left = ar_free - 2'd1;
    if (d1 && cls1 == CLS_M) mr_left = mr_free - 2'd1;
    case (cls2)
      CLS_A:   d2 = d1 && (ar_left != 2'd0);
      CLS_M:   d2 = d1 && (mr_left != 2'd0);
      default: d2 = d1;
    endcase
    if (pair_dep) d2 = 1'b0;
  end

  assign bus.select_instruction = rst_n ? {d2, d1} : 2'b00;

  idu_slot_reg #(.TYPE_W(TYPE_W), .REG_W(REG_W)) u_slot1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (d1),
    .type_i (type1_clean),
    .dst_i  (bus.IDU_in_inst1_destination_reg),
    .src1_i (bus.IDU_in_inst1_source_reg1),
    .src2_i (bus.IDU_in_inst1_source_reg2),
    .type_o (bus.IDU_out_inst1_type),
    .dst_o  (bus.IDU_out_inst1_destination_reg),
    .src1_o (bus.IDU_out_inst1_source_reg1),
    .src2_o (bus.IDU_out_inst1_source_reg2)
  );

  idu_slot_reg #(.TYPE_W(TYPE_W), .REG_W(REG_W)) u_slot2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (d2),
    .type_i (type2_clean),
    .dst_i  (bus.IDU_in_inst2_destination_reg),
    .src1_i (bus.IDU_in_inst2_source_reg1),
    .src2_i (bus.IDU_in_inst2_source_reg2),
    .type_o (bus.IDU_out_inst2_type),
    .dst_o  (bus.IDU_out_inst2_destination_reg),
    .src1_o (bus.IDU_out_inst2_source_reg1),
    .src2_o (bus.IDU_out_inst2_source_reg2)
  );

endmodule

// File: tb/tb_idu_dispatch.sv
// Directed bench for idu_dispatch: each vector checks the consume mask and both
// registered slots one cycle later against hand-computed values.
module tb_idu_dispatch;

  logic clk;
  logic rst_n;
  int   checks_cnt;
  int   errors_cnt;

  idu_dispatch_if #(.TYPE_W(8), .REG_W(8)) bus ();

  idu_dispatch #(.TYPE_W(8), .REG_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Instructions packed as {type, dst, src1, src2}.
  task automatic drive(input logic [31:0] i1, input logic [31:0] i2,
                       input logic [1:0] ar, input logic [1:0] mr);
    {bus.IDU_in_inst1_type, bus.IDU_in_inst1_destination_reg,
     bus.IDU_in_inst1_source_reg1, bus.IDU_in_inst1_source_reg2} = i1;
    {bus.IDU_in_inst2_type, bus.IDU_in_inst2_destination_reg,
     bus.IDU_in_inst2_source_reg1, bus.IDU_in_inst2_source_reg2} = i2;
    bus.AR_Status = ar;
    bus.MR_Status = mr;
  endtask

  function automatic logic [31:0] out1();
    return {bus.IDU_out_inst1_type, bus.IDU_out_inst1_destination_reg,
            bus.IDU_out_inst1_source_reg1, bus.IDU_out_inst1_source_reg2};
  endfunction

  function automatic logic [31:0] out2();
    return {bus.IDU_out_inst2_type, bus.IDU_out_inst2_destination_reg,
            bus.IDU_out_inst2_source_reg1, bus.IDU_out_inst2_source_reg2};
  endfunction

  task automatic run_vec(input string tag, input logic [31:0] i1, input logic [31:0] i2,
                         input logic [1:0] ar, input logic [1:0] mr, input logic [1:0] exp_sel,
                         input logic [31:0] exp_o1, input logic [31:0] exp_o2);
    drive(i1, i2, ar, mr);
    #1;
    check({tag, ".sel"}, {30'd0, bus.select_instruction}, {30'd0, exp_sel});
    @(posedge clk);
    #1;
    check({tag, ".out1"}, out1(), exp_o1);
    check({tag, ".out2"}, out2(), exp_o2);
    $display("vec %s sel=%b out1=%08h out2=%08h", tag, bus.select_instruction, out1(), out2());
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n = 1'b0;
    drive(32'h01020001, 32'h01050304, 2'd2, 2'd2);
    repeat (2) @(posedge clk);
    #1;
    check("rst.sel",  {30'd0, bus.select_instruction}, 32'd0);
    check("rst.out1", out1(), 32'h0);
    check("rst.out2", out2(), 32'h0);
    $display("vec reset sel=%b out1=%08h out2=%08h", bus.select_instruction, out1(), out2());
    rst_n = 1'b1;

    run_vec("dual_add",   32'h01020001, 32'h01050304, 2'd2, 2'd0, 2'b11, 32'h01020001, 32'h01050304);
    run_vec("ar_one",     32'h01020001, 32'h01050304, 2'd1, 2'd0, 2'b01, 32'h01020001, 32'h00000000);
    run_vec("in_order",   32'h03060102, 32'h01030000, 2'd2, 2'd0, 2'b00, 32'h00000000, 32'h00000000);
    run_vec("div_illeg",  32'h04070102, 32'hFF010203, 2'd0, 2'd1, 2'b11, 32'h04070102, 32'h00010203);
    run_vec("ar_three",   32'h01010203, 32'h02040506, 2'd3, 2'd0, 2'b11, 32'h01010203, 32'h02040506);
    run_vec("mul_mr1",    32'h03010203, 32'h04040506, 2'd0, 2'd1, 2'b01, 32'h03010203, 32'h00000000);
    run_vec("mul_mr2",    32'h03010203, 32'h04040506, 2'd0, 2'd2, 2'b11, 32'h03010203, 32'h04040506);
    run_vec("nop_mul",    32'h00010203, 32'h03040506, 2'd2, 2'd0, 2'b01, 32'h00010203, 32'h00000000);
    run_vec("add_mul",    32'h01010203, 32'h03040506, 2'd1, 2'd1, 2'b11, 32'h01010203, 32'h03040506);
    run_vec("mul_add",    32'h03010203, 32'h01040506, 2'd0, 2'd1, 2'b01, 32'h03010203, 32'h00000000);
    run_vec("illeg_add",  32'h7F010203, 32'h01040506, 2'd1, 2'd0, 2'b11, 32'h00010203, 32'h01040506);
    run_vec("none_free",  32'h01010203, 32'h00000000, 2'd0, 2'd0, 2'b00, 32'h00000000, 32'h00000000);
`ifdef IDU_INTRA_PAIR_DEP_CHECK_EN
    run_vec("pair_dep",   32'h01020001, 32'h02040203, 2'd2, 2'd0, 2'b01, 32'h01020001, 32'h00000000);
`else
    run_vec("pair_dep",   32'h01020001, 32'h02040203, 2'd2, 2'd0, 2'b11, 32'h01020001, 32'h02040203);
`endif

    // Reset asserted mid-stream drops a dual dispatch that would otherwise happen.
    drive(32'h01020001, 32'h01050304, 2'd2, 2'd2);
    rst_n = 1'b0;
    #1;
    check("midrst.sel", {30'd0, bus.select_instruction}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst.out1", out1(), 32'h0);
    check("midrst.out2", out2(), 32'h0);
    $display("vec midrst sel=%b out1=%08h out2=%08h", bus.select_instruction, out1(), out2());
    rst_n = 1'b1;

    run_vec("post_rst",   32'h02030102, 32'h04050607, 2'd1, 2'd1, 2'b11, 32'h02030102, 32'h04050607);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/idu_dispatch.md
Name: idu_dispatch

Overview:
- Dual-issue, in-order instruction dispatch unit for the Tomasulo superscalar core. It sits between the decode/instruction-queue head and the reservation stations (RS).
- Each cycle it takes two decoded instructions; inst1 is older. It checks free entries in the add/sub RS (AR) and the mul/div RS (MR).
- It reports combinationally how many instructions it consumes. It drives registered dispatched-instruction fields to the RS/rename stage.

Parameters:
- TYPE_W, 8, width of the instruction type/opcode field.
- REG_W, 8, width of each architectural register specifier.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- IDU_in_inst1_type  in  TYPE_W  opcode of older instruction.
- IDU_in_inst1_destination_reg  in  REG_W  destination register of inst1.
- IDU_in_inst1_source_reg1  in  REG_W  first source register of inst1.
- IDU_in_inst1_source_reg2  in  REG_W  second source register of inst1.
- IDU_in_inst2_type, IDU_in_inst2_destination_reg, IDU_in_inst2_source_reg1, IDU_in_inst2_source_reg2  in  TYPE_W/REG_W  same fields for the younger instruction.
- AR_Status  in  2  free entries in the add/sub RS (0, 1, 2 or more; value 3 is treated as 2).
- MR_Status  in  2  free entries in the mul/div RS (same encoding as AR_Status).
- select_instruction  out  2  combinational consume mask: bit0 = inst1, bit1 = inst2.
- IDU_out_inst1_type, IDU_out_inst1_destination_reg, IDU_out_inst1_source_reg1, IDU_out_inst1_source_reg2  out  TYPE_W/REG_W  registered dispatched inst1.
- IDU_out_inst2_type, IDU_out_inst2_destination_reg, IDU_out_inst2_source_reg1, IDU_out_inst2_source_reg2  out  TYPE_W/REG_W  registered dispatched inst2.

Behaviour:
- Opcode classes:
  - NOP=8'h00: class N, needs no RS.
  - ADD=8'h01 and SUB=8'h02: class A.
  - MUL=8'h03 and DIV=8'h04: class M.
  - Any other code: treated as NOP (class N) and output as NOP.
- Free counts: a = min(AR_Status, 2), m = min(MR_Status, 2).
- Dispatch rule for inst1 (d1): d1 = 1 if class N, or if its class count is at least 1. Dispatching inst1 consumes one unit of its class count.
- Dispatch rule for inst2 (d2): d2 = d1 AND (class N, or its class count remaining after inst1 is at least 1). This keeps dispatch strictly in order; inst2 is never sent alone.
- select_instruction = {d2, d1}. Legal values are 00, 01 and 11; 10 is never produced.
- select_instruction is combinational in the same cycle, so the front end advances its queue by 0, 1 or 2 on the next clk edge.
- While rst_n = 0, select_instruction is forced to 00.
- Outputs are registered with 1-cycle latency. On the clk edge, each out slot is loaded as follows:
  - Slot dispatched: the matching input fields, with the type remapped to NOP if the opcode was illegal.
  - Slot not dispatched: type = NOP and all register fields = 0.
- Reset (rst_n low at clk edge): all IDU_out_* fields = 0 (type NOP). Reset mid-operation discards whatever would have been dispatched in that cycle.
- A read-after-write or write-after-write relationship between inst1 and inst2 does not block dual dispatch; renaming downstream resolves it.
- Status inputs are sampled in the same cycle as the instructions; there is no internal RS occupancy tracking.

Optional Feature:
- Macro: IDU_INTRA_PAIR_DEP_CHECK_EN.
- When defined: d2 is additionally forced to 0 if inst1 is class A or M and inst1's destination equals inst2's source_reg1 or source_reg2. Such an inst2 waits one cycle and is re-presented as inst1.
- When undefined: no intra-pair register comparison is made.

Decomposition:
- Shared package idu_pkg:
  - TYPE_W and REG_W.
  - Opcode constants NOP, ADD, SUB, MUL, DIV.
  - Register constants R0..R7 = 8'h00..8'h07.
  - Class enum {CLS_N, CLS_A, CLS_M}.
  - Function that maps an opcode to its class.
- Sub-module idu_slot_reg: the per-slot output register holding type plus three register fields, with load, NOP-fill and reset. It is instantiated twice.

Test Plan:
- Reset: hold rst_n = 0 for 2 clk with ADD inputs present -> all outputs 0, select_instruction = 00.
- Dual dispatch:
  - Stimulus: inst1 = ADD R2,R0,R1; inst2 = ADD R5,R3,R4; AR_Status = 2; MR_Status = 0.
  - Response: select = 11. Next cycle out1 = {01,02,00,01} and out2 = {01,05,03,04}.
- Single-slot limit: same two ADDs with AR_Status = 1 -> select = 01; out1 = ADD R2,R0,R1; out2 = NOP with register fields 0.
- In-order block:
  - Stimulus: inst1 = MUL R6,R1,R2; inst2 = ADD R3,R0,R0; MR_Status = 0; AR_Status = 2.
  - Response: select = 00; both outputs NOP.
- Mixed classes and illegal opcode:
  - Stimulus: inst1 = DIV R7,R1,R2 with MR_Status = 1; inst2 = type 8'hFF.
  - Response: select = 11; out1 = DIV; out2 type = NOP.
- With IDU_INTRA_PAIR_DEP_CHECK_EN defined:
  - Stimulus: inst1 = ADD R2,R0,R1; inst2 = SUB R4,R2,R3; AR_Status = 2.
  - Response: select = 01. Without the macro, select = 11.
